shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 21 ++
 rtl/shift_arbiter_shift_left.sv | 22 ++
 rtl/shift_arbiter.sv | 122 ++++++++++++
 tb/tb_shift_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : shift_arbiter_pkg                                             |
// | Description : Shared types and default parameters for shift_arbiter.        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

package shift_arbiter_pkg;

  localparam int c_N_DEFAULT = 16;
  localparam int c_S_DEFAULT = 4;
  localparam int c_R_DEFAULT = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_shift_left.sv
// +-----------------------------------------------------------------------------+
// | Module      : shift_left                                                    |
// | Description : Combinational logical left shift, result truncated to N bits. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module shift_left #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] y
);

  // Shift amounts of N or more naturally produce zero.
  assign y = a << b;

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : shift_arbiter                                                 |
// | Description : Round-robin arbiter sharing one left shifter among R clients, |
// |               with a single-entry registered result stage.                  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N  = c_N_DEFAULT,
  parameter int S  = c_S_DEFAULT,
  parameter int R  = c_R_DEFAULT,
  parameter int IW = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req_valid,
  output logic [R-1:0]         req_ready,
  input  logic [R-1:0][N-1:0]  req_a,
  input  logic [R-1:0][S-1:0]  req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N-1:0]         res_data,
  output logic [IW-1:0]        res_id
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [N-1:0]  r_data;
  logic [IW-1:0] r_id;

  logic [IW:0]   w_idx;
  logic [IW-1:0] w_gidx;
  logic          w_found;
  logic          w_free;
  logic          w_grant;
  logic [N-1:0]  w_sel_a;
  logic [S-1:0]  w_sel_b;
  logic [N-1:0]  w_shift;

  // Round-robin search starting at r_ptr; first valid index wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < R; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(R)) begin
        w_idx = w_idx - (IW+1)'(R);
      end
      if (!w_found && req_valid[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[IW-1:0];
      end
    end
  end

  // rst_n gates the grant so no requester is accepted while reset is held.
  assign w_free  = rst_n && ((r_state == EMPTY) || res_ready);
  assign w_grant = w_free && w_found;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_gidx == IW'(R-1)) ? '0 : w_gidx + 1'b1;

  assign w_sel_a = req_a[w_gidx];
  assign w_sel_b = req_b[w_gidx];

  shift_left #(
    .N (N),
    .S (S)
  ) u_shift_left (
    .a (w_sel_a),
    .b (w_sel_b),
    .y (w_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_grant) w_state_nxt = FULL;
      FULL:    if (res_ready && !w_grant) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_data <= w_shift;
      r_id   <= w_gidx;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign res_valid = (r_state == FULL);
  assign res_data  = r_data;
  assign res_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_shift_arbiter                                              |
// | Description : Directed-vector and scoreboard bench for shift_arbiter.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][15:0] req_a;
  logic [3:0][3:0]  req_b;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [1:0]       res_id;

  int checks;
  int failures;

  shift_arbiter #(.N(16), .S(4), .R(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [3:0]  b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [15:0] exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic [3:0] v, logic [15:0] a, logic [3:0] b, logic rr,
                              logic [3:0] er, logic erv, logic [15:0] ed, logic [1:0] eid);
    vec_t t;
    t.valid = v; t.a = a; t.b = b; t.rr = rr;
    t.exp_ready = er; t.exp_rv = erv; t.exp_data = ed; t.exp_id = eid;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Valid requesters get (a,b); idle ones carry junk so a wrong mux shows up.
  task automatic drive_ops(input logic [3:0] v, input logic [15:0] a, input logic [3:0] b);
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = v[i] ? a : 16'hA5A5;
      req_b[i] = v[i] ? b : 4'd3;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_ops(4'b0000, 16'h0, 4'd0);
    res_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [15:0] rr_exp [4];
  logic [3:0]  pend;
  logic [15:0] op_a [4];
  logic [3:0]  op_b [4];
  int          wait_cnt [4];
  logic        have;
  logic [15:0] sb_data;
  logic [1:0]  sb_id;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    res_ready = 1'b1;
    drive_ops(4'b1111, 16'h1234, 4'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", {28'd0, req_ready}, 32'h0);
    chk("reset_valid", {31'd0, res_valid}, 32'h0);
    chk("reset_data", {16'd0, res_data}, 32'h0);
    chk("reset_id", {30'd0, res_id}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    tbl[0]  = mk(4'b0001, 16'h0003, 4'd4,  1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0);
    tbl[1]  = mk(4'b0000, 16'h0000, 4'd0,  1'b1, 4'b0000, 1'b1, 16'h0030, 2'd0);
    tbl[2]  = mk(4'b0100, 16'hFFFF, 4'd0,  1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0);
    tbl[3]  = mk(4'b0100, 16'hFFFF, 4'd15, 1'b1, 4'b0100, 1'b1, 16'hFFFF, 2'd2);
    tbl[4]  = mk(4'b1000, 16'h0001, 4'd15, 1'b1, 4'b1000, 1'b1, 16'h8000, 2'd2);
    tbl[5]  = mk(4'b0010, 16'h1234, 4'd8,  1'b0, 4'b0000, 1'b1, 16'h8000, 2'd3);
    tbl[6]  = mk(4'b0010, 16'h1234, 4'd8,  1'b1, 4'b0010, 1'b1, 16'h8000, 2'd3);
    tbl[7]  = mk(4'b0011, 16'h0F0F, 4'd4,  1'b1, 4'b0001, 1'b1, 16'h3400, 2'd1);
    tbl[8]  = mk(4'b0011, 16'h0F0F, 4'd4,  1'b1, 4'b0010, 1'b1, 16'hF0F0, 2'd0);
    tbl[9]  = mk(4'b0000, 16'h0000, 4'd0,  1'b0, 4'b0000, 1'b1, 16'hF0F0, 2'd1);
    tbl[10] = mk(4'b0000, 16'h0000, 4'd0,  1'b1, 4'b0000, 1'b1, 16'hF0F0, 2'd1);
    tbl[11] = mk(4'b0000, 16'h0000, 4'd0,  1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0);

    for (int v = 0; v < 12; v++) begin
      drive_ops(tbl[v].valid, tbl[v].a, tbl[v].b);
      res_ready = tbl[v].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", v), {28'd0, req_ready}, {28'd0, tbl[v].exp_ready});
      chk($sformatf("tbl%0d_valid", v), {31'd0, res_valid}, {31'd0, tbl[v].exp_rv});
      if (tbl[v].exp_rv) begin
        chk($sformatf("tbl%0d_data", v), {16'd0, res_data}, {16'd0, tbl[v].exp_data});
        chk($sformatf("tbl%0d_id", v), {30'd0, res_id}, {30'd0, tbl[v].exp_id});
      end
      @(posedge clk);
      #1;
    end

    // Round-robin with distinct operands per requester.
    do_reset();
    rr_exp[0] = 16'h0001; rr_exp[1] = 16'h0004; rr_exp[2] = 16'h000C; rr_exp[3] = 16'h0020;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 16'(i + 1);
      req_b[i] = 4'(i);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_ready", k), {28'd0, req_ready}, 32'd1 << (k % 4));
      if (k >= 1) begin
        chk($sformatf("rr%0d_valid", k), {31'd0, res_valid}, 32'd1);
        chk($sformatf("rr%0d_id", k), {30'd0, res_id}, 32'((k - 1) % 4));
        chk($sformatf("rr%0d_data", k), {16'd0, res_data}, {16'd0, rr_exp[(k - 1) % 4]});
      end
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rr_last_id", {30'd0, res_id}, 32'd3);
    chk("rr_last_data", {16'd0, res_data}, 32'h20);
    @(posedge clk);
    #1;

    // Backpressure: held result must stay put and block new grants.
    do_reset();
    drive_ops(4'b0100, 16'h8001, 4'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant", {28'd0, req_ready}, 32'b0100);
    @(posedge clk);
    #1;
    drive_ops(4'b1111, 16'h0101, 4'd2);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", k), {28'd0, req_ready}, 32'h0);
      chk($sformatf("bp%0d_valid", k), {31'd0, res_valid}, 32'd1);
      chk($sformatf("bp%0d_data", k), {16'd0, res_data}, 32'h0002);
      chk($sformatf("bp%0d_id", k), {30'd0, res_id}, 32'd2);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_grant", {28'd0, req_ready}, 32'b1000);
    @(posedge clk);
    #1;

    // Mid-operation reset while FULL with ptr=3.
    do_reset();
    drive_ops(4'b0100, 16'h8001, 4'd1);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    drive_ops(4'b0000, 16'h0, 4'd0);
    res_ready = 1'b0;
    @(negedge clk);
    chk("mr_full", {31'd0, res_valid}, 32'd1);
    drive_ops(4'b1111, 16'h0001, 4'd1);
    res_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, res_valid}, 32'd0);
    chk("mr_ready", {28'd0, req_ready}, 32'h0);
    chk("mr_data", {16'd0, res_data}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mr_first_grant", {28'd0, req_ready}, 32'b0001);
    @(posedge clk);
    #1;

    // Random stress with a one-entry scoreboard and starvation bound.
    do_reset();
    pend = '0;
    have = 1'b0;
    sb_data = '0;
    sb_id = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cnt[i] = 0;
      op_a[i] = '0;
      op_b[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1'b1;
          op_a[i] = 16'($urandom);
          op_b[i] = 4'($urandom);
        end
        req_a[i] = pend[i] ? op_a[i] : 16'($urandom);
        req_b[i] = pend[i] ? op_b[i] : 4'($urandom);
      end
      req_valid = pend;
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if ((req_ready & ~req_valid) != 4'b0000) chk("st_ready_invalid", {28'd0, req_ready}, {28'd0, req_ready & req_valid});
      if (!$onehot0(req_ready)) chk("st_onehot", {28'd0, req_ready}, 32'h0);
      if (res_valid !== have) chk("st_valid", {31'd0, res_valid}, {31'd0, have});
      if (have && res_ready) begin
        chk("st_data", {16'd0, res_data}, {16'd0, sb_data});
        chk("st_id", {30'd0, res_id}, {30'd0, sb_id});
        have = 1'b0;
      end
      if ((!res_valid || res_ready) && (req_valid != 4'b0000) && (req_ready == 4'b0000))
        chk("st_missing_grant", {28'd0, req_ready}, 32'hF);
      if (res_valid && !res_ready && (req_ready != 4'b0000))
        chk("st_grant_when_full", {28'd0, req_ready}, 32'h0);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          have = 1'b1;
          sb_data = 16'(op_a[i] << op_b[i]);
          sb_id = 2'(i);
          pend[i] = 1'b0;
          wait_cnt[i] = 0;
        end
      end
      if (req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i] && !req_ready[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > 3) chk($sformatf("st_starve%0d", i), 32'(wait_cnt[i]), 32'd3);
          end
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
